// File: rtl/uart_pkt_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkt_pkg
// Shared types and constants for the multi-buffered UART packet receiver.
//   err_e      : error codes reported on err_code
//   wr_state_e : frame parser (write side) states
//   rd_state_e : drain (read side) states
//   DEFAULT_HDR0/DEFAULT_HDR1 : default frame header bytes
//   clog2_min1 : $clog2 that never returns 0, for sizing index registers
// -----------------------------------------------------------------------------
package uart_pkt_pkg;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_LEN     = 3'd1,
    ERR_CHK     = 3'd2,
    ERR_TIMEOUT = 3'd3,
    ERR_NOBUF   = 3'd4
  } err_e;

  typedef enum logic [2:0] {
    WR_HUNT,
    WR_HDR1,
    WR_CMD,
    WR_LEN_L,
    WR_LEN_H,
    WR_PAYLOAD,
    WR_CHECK
  } wr_state_e;

  typedef enum logic {
    RD_META,
    RD_PAYLOAD
  } rd_state_e;

  localparam logic [7:0] DEFAULT_HDR0 = 8'hAA;
  localparam logic [7:0] DEFAULT_HDR1 = 8'h55;

  // Index registers need at least one bit even when only one entry exists.
  function automatic int clog2_min1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/uart_pkt_slot_ram.sv
// -----------------------------------------------------------------------------
// uart_pkt_slot_ram
// Payload storage: NUM_BUFS slots of DEPTH bytes, addressed as {slot, offset}.
// One synchronous write port, one asynchronous (combinational) read port.
// Ports:
//   clk        : system clock
//   wr_en_i    : write strobe
//   wr_slot_i  : write slot index
//   wr_off_i   : write byte offset within slot
//   wr_data_i  : write data byte
//   rd_slot_i  : read slot index
//   rd_off_i   : read byte offset within slot
//   rd_data_o  : read data byte (combinational)
// -----------------------------------------------------------------------------
module uart_pkt_slot_ram
  import uart_pkt_pkg::*;
#(
  parameter int NUM_BUFS = 2,
  parameter int DEPTH    = 512,
  parameter int SLOT_W   = clog2_min1(NUM_BUFS),
  parameter int OFF_W    = clog2_min1(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [SLOT_W-1:0] wr_slot_i,
  input  logic [OFF_W-1:0]  wr_off_i,
  input  logic [7:0]        wr_data_i,
  input  logic [SLOT_W-1:0] rd_slot_i,
  input  logic [OFF_W-1:0]  rd_off_i,
  output logic [7:0]        rd_data_o
);

  logic [7:0] mem [NUM_BUFS][DEPTH];

  // Plain RAM write; contents are deliberately not reset so this maps onto
  // memory macros or distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem[wr_slot_i][wr_off_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem[rd_slot_i][rd_off_i];

endmodule

// File: rtl/uart_packet_rx_mb.sv
// -----------------------------------------------------------------------------
// uart_packet_rx_mb
// Multi-buffered UART frame depacketizer. Parses
//   HDR0 HDR1 CMD LEN_L LEN_H PAYLOAD[LEN] CHK,  CHK = ~(CMD+LEN_L+LEN_H+payload)
// from the byte stream, commits good frames into NUM_BUFS payload slots and
// drains them as a metadata handshake followed by a payload byte stream.
// Build option: define UART_PKT_STATS_EN to build the saturating good/bad
// frame counters; otherwise stat_good/stat_bad are tied to 0.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   rx_byte/_valid/_ready : incoming bytes (ready is constant 1)
//   pkt_meta_valid/_ready : head-slot metadata handshake (pkt_cmd, pkt_length)
//   pkt_payload_*         : payload byte stream with last marker
//   err_valid/err_code    : one-cycle error pulse and sticky code
//   buf_count             : committed, undrained slots
//   stat_good/stat_bad    : optional statistics counters
// -----------------------------------------------------------------------------
module uart_packet_rx_mb
  import uart_pkt_pkg::*;
#(
  parameter int         MAX_PAYLOAD_BYTES = 512,
  parameter int         NUM_BUFS          = 2,
  parameter int         TIMEOUT_CYCLES    = 100000,
  parameter logic [7:0] HDR0              = DEFAULT_HDR0,
  parameter logic [7:0] HDR1              = DEFAULT_HDR1,
  parameter int         STAT_WIDTH        = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    rx_byte,
  input  logic                          rx_byte_valid,
  output logic                          rx_byte_ready,
  output logic                          pkt_meta_valid,
  input  logic                          pkt_meta_ready,
  output logic [7:0]                    pkt_cmd,
  output logic [15:0]                   pkt_length,
  output logic [7:0]                    pkt_payload_data,
  output logic                          pkt_payload_valid,
  output logic                          pkt_payload_last,
  input  logic                          pkt_payload_ready,
  output logic                          err_valid,
  output logic [2:0]                    err_code,
  output logic [$clog2(NUM_BUFS+1)-1:0] buf_count,
  output logic [STAT_WIDTH-1:0]         stat_good,
  output logic [STAT_WIDTH-1:0]         stat_bad
);

  localparam int CNT_W  = $clog2(NUM_BUFS + 1);
  localparam int SLOT_W = clog2_min1(NUM_BUFS);
  localparam int OFF_W  = clog2_min1(MAX_PAYLOAD_BYTES);
  localparam int IDLE_W = clog2_min1(TIMEOUT_CYCLES);

  localparam bit                TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(NUM_BUFS - 1);
  localparam logic [CNT_W-1:0]  NUM_BUFS_C = CNT_W'(NUM_BUFS);

  // Write side state
  wr_state_e         wrState_q;
  logic [7:0]        cmd_q;
  logic [15:0]       len_q;
  logic [15:0]       wrOff_q;
  logic [7:0]        sum_q;
  logic [IDLE_W-1:0] idle_q;
  logic [SLOT_W-1:0] wrSlot_q;
  logic              errValid_q;
  err_e              errCode_q;

  // Per-slot metadata, written on commit
  logic [7:0]        slotCmd_q [NUM_BUFS];
  logic [15:0]       slotLen_q [NUM_BUFS];

  // Read side state
  rd_state_e         rdState_q;
  logic [SLOT_W-1:0] rdSlot_q;
  logic [15:0]       rdOff_q;
  logic              metaValid_q;
  logic [CNT_W-1:0]  bufCount_q;
  logic [CNT_W-1:0]  bufCount_d;

  logic [15:0]       lenFull;
  logic              commitFrame;
  logic              ramWrEn;
  logic [7:0]        ramRdData;
  logic [7:0]        headCmd;
  logic [15:0]       headLen;
  logic              metaHs;
  logic              payValid;
  logic              payLast;
  logic              payHs;
  logic              slotFree;

  assign lenFull     = {rx_byte, len_q[7:0]};
  assign commitFrame = (wrState_q == WR_CHECK) && rx_byte_valid && (rx_byte == ~sum_q);
  assign ramWrEn     = (wrState_q == WR_PAYLOAD) && rx_byte_valid;

  // Frame parser. Header/length/checksum checking, payload writes into the
  // current write slot and the mid-frame inactivity timeout all live here.
  // The write slot is guaranteed free because HDR1 refuses to start a frame
  // when every slot is occupied, and occupancy cannot grow mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrState_q  <= WR_HUNT;
      cmd_q      <= '0;
      len_q      <= '0;
      wrOff_q    <= '0;
      sum_q      <= '0;
      idle_q     <= '0;
      wrSlot_q   <= '0;
      errValid_q <= 1'b0;
      errCode_q  <= ERR_NONE;
      for (int i = 0; i < NUM_BUFS; i++) begin
        slotCmd_q[i] <= '0;
        slotLen_q[i] <= '0;
      end
    end else begin
      errValid_q <= 1'b0;
      if (rx_byte_valid) begin
        idle_q <= '0;
        case (wrState_q)
          WR_HUNT: begin
            if (rx_byte == HDR0) begin
              wrState_q <= WR_HDR1;
            end
          end
          WR_HDR1: begin
            if (rx_byte == HDR1) begin
              if (bufCount_q < NUM_BUFS_C) begin
                wrState_q <= WR_CMD;
              end else begin
                errValid_q <= 1'b1;
                errCode_q  <= ERR_NOBUF;
                wrState_q  <= WR_HUNT;
              end
            end else if (rx_byte != HDR0) begin
              wrState_q <= WR_HUNT;
            end
          end
          WR_CMD: begin
            cmd_q     <= rx_byte;
            sum_q     <= rx_byte;
            wrState_q <= WR_LEN_L;
          end
          WR_LEN_L: begin
            len_q[7:0] <= rx_byte;
            sum_q      <= sum_q + rx_byte;
            wrState_q  <= WR_LEN_H;
          end
          WR_LEN_H: begin
            len_q   <= lenFull;
            sum_q   <= sum_q + rx_byte;
            wrOff_q <= '0;
            if (int'(lenFull) > MAX_PAYLOAD_BYTES) begin
              // Oversized payload bytes are simply hunted through.
              errValid_q <= 1'b1;
              errCode_q  <= ERR_LEN;
              wrState_q  <= WR_HUNT;
            end else if (lenFull == 16'd0) begin
              wrState_q <= WR_CHECK;
            end else begin
              wrState_q <= WR_PAYLOAD;
            end
          end
          WR_PAYLOAD: begin
            sum_q   <= sum_q + rx_byte;
            wrOff_q <= wrOff_q + 16'd1;
            if (wrOff_q == len_q - 16'd1) begin
              wrState_q <= WR_CHECK;
            end
          end
          WR_CHECK: begin
            if (commitFrame) begin
              slotCmd_q[wrSlot_q] <= cmd_q;
              slotLen_q[wrSlot_q] <= len_q;
              wrSlot_q <= (wrSlot_q == SLOT_LAST) ? '0 : wrSlot_q + SLOT_W'(1);
            end else begin
              // Slot stays put; its contents get overwritten by the next frame.
              errValid_q <= 1'b1;
              errCode_q  <= ERR_CHK;
            end
            wrState_q <= WR_HUNT;
          end
          default: wrState_q <= WR_HUNT;
        endcase
      end else if (TIMEOUT_EN && (wrState_q != WR_HUNT)) begin
        if (idle_q == IDLE_LAST) begin
          errValid_q <= 1'b1;
          errCode_q  <= ERR_TIMEOUT;
          idle_q     <= '0;
          wrState_q  <= WR_HUNT;
        end else begin
          idle_q <= idle_q + IDLE_W'(1);
        end
      end
    end
  end

  uart_pkt_slot_ram #(
    .NUM_BUFS (NUM_BUFS),
    .DEPTH    (MAX_PAYLOAD_BYTES),
    .SLOT_W   (SLOT_W),
    .OFF_W    (OFF_W)
  ) u_slot_ram (
    .clk       (clk),
    .wr_en_i   (ramWrEn),
    .wr_slot_i (wrSlot_q),
    .wr_off_i  (wrOff_q[OFF_W-1:0]),
    .wr_data_i (rx_byte),
    .rd_slot_i (rdSlot_q),
    .rd_off_i  (rdOff_q[OFF_W-1:0]),
    .rd_data_o (ramRdData)
  );

  assign headCmd  = slotCmd_q[rdSlot_q];
  assign headLen  = slotLen_q[rdSlot_q];
  assign metaHs   = metaValid_q && pkt_meta_ready;
  assign payValid = (rdState_q == RD_PAYLOAD);
  assign payLast  = payValid && (rdOff_q == headLen - 16'd1);
  assign payHs    = payValid && pkt_payload_ready;
  assign slotFree = (metaHs && (headLen == 16'd0)) || (payHs && payLast);

  // Occupancy: a commit and a free in the same cycle cancel out.
  always_comb begin
    bufCount_d = bufCount_q;
    if (commitFrame && !slotFree) begin
      bufCount_d = bufCount_q + CNT_W'(1);
    end else if (!commitFrame && slotFree) begin
      bufCount_d = bufCount_q - CNT_W'(1);
    end
  end

  // Drain FSM. Meta valid is computed from next-cycle occupancy so it rises
  // together with the commit, and it can only fall through a handshake since
  // occupancy only shrinks when the head slot is freed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdState_q   <= RD_META;
      rdSlot_q    <= '0;
      rdOff_q     <= '0;
      metaValid_q <= 1'b0;
      bufCount_q  <= '0;
    end else begin
      bufCount_q <= bufCount_d;
      if (slotFree) begin
        rdSlot_q <= (rdSlot_q == SLOT_LAST) ? '0 : rdSlot_q + SLOT_W'(1);
      end
      case (rdState_q)
        RD_META: begin
          if (metaHs && (headLen != 16'd0)) begin
            rdState_q   <= RD_PAYLOAD;
            rdOff_q     <= '0;
            metaValid_q <= 1'b0;
          end else begin
            metaValid_q <= (bufCount_d != '0);
          end
        end
        RD_PAYLOAD: begin
          if (payHs) begin
            if (payLast) begin
              rdState_q   <= RD_META;
              rdOff_q     <= '0;
              metaValid_q <= (bufCount_d != '0);
            end else begin
              rdOff_q <= rdOff_q + 16'd1;
            end
          end
        end
        default: rdState_q <= RD_META;
      endcase
    end
  end

  assign rx_byte_ready     = 1'b1;
  assign pkt_meta_valid    = metaValid_q;
  assign pkt_cmd           = headCmd;
  assign pkt_length        = headLen;
  assign pkt_payload_valid = payValid;
  assign pkt_payload_last  = payLast;
  assign pkt_payload_data  = payValid ? ramRdData : 8'h00;
  assign err_valid         = errValid_q;
  assign err_code          = errCode_q;
  assign buf_count         = bufCount_q;

`ifdef UART_PKT_STATS_EN
  logic [STAT_WIDTH-1:0] statGood_q;
  logic [STAT_WIDTH-1:0] statBad_q;

  // Saturating counters: good frames count on commit, bad ones on each
  // error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      statGood_q <= '0;
      statBad_q  <= '0;
    end else begin
      if (commitFrame && (statGood_q != '1)) begin
        statGood_q <= statGood_q + STAT_WIDTH'(1);
      end
      if (errValid_q && (statBad_q != '1)) begin
        statBad_q <= statBad_q + STAT_WIDTH'(1);
      end
    end
  end

  assign stat_good = statGood_q;
  assign stat_bad  = statBad_q;
`else
  assign stat_good = '0;
  assign stat_bad  = '0;
`endif

endmodule

// File: tb/tb_uart_packet_rx_mb.sv
// -----------------------------------------------------------------------------
// tb_uart_packet_rx_mb
// Directed bench for uart_packet_rx_mb with NUM_BUFS=2, MAX_PAYLOAD_BYTES=512
// and TIMEOUT_CYCLES=50. Expected values are hand-computed constants.
// Honors UART_PKT_STATS_EN for the statistics counter expectations.
// -----------------------------------------------------------------------------
module tb_uart_packet_rx_mb;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  logic        rx_byte_ready;
  logic        pkt_meta_valid;
  logic        pkt_meta_ready;
  logic [7:0]  pkt_cmd;
  logic [15:0] pkt_length;
  logic [7:0]  pkt_payload_data;
  logic        pkt_payload_valid;
  logic        pkt_payload_last;
  logic        pkt_payload_ready;
  logic        err_valid;
  logic [2:0]  err_code;
  logic [1:0]  buf_count;
  logic [15:0] stat_good;
  logic [15:0] stat_bad;

  int assertCount;
  int failCount;

`ifdef UART_PKT_STATS_EN
  localparam int STATS_ON = 1;
`else
  localparam int STATS_ON = 0;
`endif

  uart_packet_rx_mb #(
    .MAX_PAYLOAD_BYTES (512),
    .NUM_BUFS          (2),
    .TIMEOUT_CYCLES    (50),
    .HDR0              (8'hAA),
    .HDR1              (8'h55),
    .STAT_WIDTH        (16)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rx_byte           (rx_byte),
    .rx_byte_valid     (rx_byte_valid),
    .rx_byte_ready     (rx_byte_ready),
    .pkt_meta_valid    (pkt_meta_valid),
    .pkt_meta_ready    (pkt_meta_ready),
    .pkt_cmd           (pkt_cmd),
    .pkt_length        (pkt_length),
    .pkt_payload_data  (pkt_payload_data),
    .pkt_payload_valid (pkt_payload_valid),
    .pkt_payload_last  (pkt_payload_last),
    .pkt_payload_ready (pkt_payload_ready),
    .err_valid         (err_valid),
    .err_code          (err_code),
    .buf_count         (buf_count),
    .stat_good         (stat_good),
    .stat_bad          (stat_bad)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and land 1 ns after the rising edge
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Present one byte for exactly one clock, then sample point follows
  task automatic applyStimulus(input logic [7:0] b);
    rx_byte       = b;
    rx_byte_valid = 1'b1;
    stepCycle();
    rx_byte_valid = 1'b0;
    rx_byte       = 8'h00;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    assertCount       = 0;
    failCount         = 0;
    rst_n             = 1'b0;
    rx_byte           = 8'h00;
    rx_byte_valid     = 1'b0;
    pkt_meta_ready    = 1'b0;
    pkt_payload_ready = 1'b0;

    // Reset state
    repeat (3) stepCycle();
    checkOutput("rst_ready",    32'(rx_byte_ready),     32'd1);
    checkOutput("rst_meta",     32'(pkt_meta_valid),    32'd0);
    checkOutput("rst_payvalid", 32'(pkt_payload_valid), 32'd0);
    checkOutput("rst_paydata",  32'(pkt_payload_data),  32'd0);
    checkOutput("rst_last",     32'(pkt_payload_last),  32'd0);
    checkOutput("rst_errv",     32'(err_valid),         32'd0);
    checkOutput("rst_errc",     32'(err_code),          32'd0);
    checkOutput("rst_bufcnt",   32'(buf_count),         32'd0);
    checkOutput("rst_cmd",      32'(pkt_cmd),           32'd0);
    checkOutput("rst_len",      32'(pkt_length),        32'd0);
    checkOutput("rst_sgood",    32'(stat_good),         32'd0);
    checkOutput("rst_sbad",     32'(stat_bad),          32'd0);
    rst_n = 1'b1;
    stepCycle();

    // 1. Good frame with 3-byte payload
    $display("[TB] good frame");
    applyStimulus(8'hAA); applyStimulus(8'h55); applyStimulus(8'h10);
    applyStimulus(8'h03); applyStimulus(8'h00);
    applyStimulus(8'h01); applyStimulus(8'h02); applyStimulus(8'h03);
    checkOutput("t1_meta_early", 32'(pkt_meta_valid), 32'd0);
    applyStimulus(8'hE6);
    checkOutput("t1_meta",   32'(pkt_meta_valid), 32'd1);
    checkOutput("t1_cmd",    32'(pkt_cmd),        32'h10);
    checkOutput("t1_len",    32'(pkt_length),     32'd3);
    checkOutput("t1_bufcnt", 32'(buf_count),      32'd1);
    checkOutput("t1_errv",   32'(err_valid),      32'd0);
    checkOutput("t1_sgood",  32'(stat_good),      32'(STATS_ON));
    pkt_meta_ready = 1'b1;
    stepCycle();
    pkt_meta_ready = 1'b0;
    checkOutput("t1_meta_drop", 32'(pkt_meta_valid),    32'd0);
    checkOutput("t1_pv0",       32'(pkt_payload_valid), 32'd1);
    checkOutput("t1_pd0",       32'(pkt_payload_data),  32'h01);
    checkOutput("t1_pl0",       32'(pkt_payload_last),  32'd0);
    pkt_payload_ready = 1'b1;
    stepCycle();
    checkOutput("t1_pd1", 32'(pkt_payload_data), 32'h02);
    checkOutput("t1_pl1", 32'(pkt_payload_last), 32'd0);
    stepCycle();
    checkOutput("t1_pd2", 32'(pkt_payload_data), 32'h03);
    checkOutput("t1_pl2", 32'(pkt_payload_last), 32'd1);
    stepCycle();
    pkt_payload_ready = 1'b0;
    checkOutput("t1_pv_end",  32'(pkt_payload_valid), 32'd0);
    checkOutput("t1_buf_end", 32'(buf_count),         32'd0);
    checkOutput("t1_meta_end", 32'(pkt_meta_valid),   32'd0);

    // 2. Bad checksum
    $display("[TB] bad checksum");
    applyStimulus(8'hAA); applyStimulus(8'h55); applyStimulus(8'h10);
    applyStimulus(8'h03); applyStimulus(8'h00);
    applyStimulus(8'h01); applyStimulus(8'h02); applyStimulus(8'h03);
    applyStimulus(8'h00);
    checkOutput("t2_errv",   32'(err_valid),      32'd1);
    checkOutput("t2_errc",   32'(err_code),       32'd2);
    checkOutput("t2_meta",   32'(pkt_meta_valid), 32'd0);
    checkOutput("t2_bufcnt", 32'(buf_count),      32'd0);
    stepCycle();
    checkOutput("t2_errv_pulse", 32'(err_valid), 32'd0);
    checkOutput("t2_errc_hold",  32'(err_code),  32'd2);

    // 3. Length overflow (0x0201 = 513), then a zero-length frame
    $display("[TB] length overflow");
    applyStimulus(8'hAA); applyStimulus(8'h55); applyStimulus(8'h10);
    applyStimulus(8'h01);
    checkOutput("t3_errv_early", 32'(err_valid), 32'd0);
    applyStimulus(8'h02);
    checkOutput("t3_errv", 32'(err_valid), 32'd1);
    checkOutput("t3_errc", 32'(err_code),  32'd1);
    applyStimulus(8'hAA); applyStimulus(8'h55); applyStimulus(8'h20);
    applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'hDF);

    // 4. Zero-length frame accepted and freed on meta handshake
    checkOutput("t4_meta",   32'(pkt_meta_valid),    32'd1);
    checkOutput("t4_cmd",    32'(pkt_cmd),           32'h20);
    checkOutput("t4_len",    32'(pkt_length),        32'd0);
    checkOutput("t4_bufcnt", 32'(buf_count),         32'd1);
    checkOutput("t4_pv",     32'(pkt_payload_valid), 32'd0);
    pkt_meta_ready = 1'b1;
    stepCycle();
    pkt_meta_ready = 1'b0;
    checkOutput("t4_meta_end", 32'(pkt_meta_valid),    32'd0);
    checkOutput("t4_buf_end",  32'(buf_count),         32'd0);
    checkOutput("t4_pv_end",   32'(pkt_payload_valid), 32'd0);

    // 5. Overrun: two frames fill both slots, third is refused
    $display("[TB] overrun");
    applyStimulus(8'hAA); applyStimulus(8'h55); applyStimulus(8'h31);
    applyStimulus(8'h01); applyStimulus(8'h00); applyStimulus(8'h7E);
    applyStimulus(8'h4F);
    checkOutput("t5_buf1", 32'(buf_count), 32'd1);
    applyStimulus(8'hAA); applyStimulus(8'h55); applyStimulus(8'h32);
    applyStimulus(8'h02); applyStimulus(8'h00); applyStimulus(8'h11);
    applyStimulus(8'h22); applyStimulus(8'h98);
    checkOutput("t5_buf2", 32'(buf_count), 32'd2);
    applyStimulus(8'hAA); applyStimulus(8'h55);
    checkOutput("t5_errv", 32'(err_valid), 32'd1);
    checkOutput("t5_errc", 32'(err_code),  32'd4);
    applyStimulus(8'h33); applyStimulus(8'h00); applyStimulus(8'h00);
    applyStimulus(8'hCC);
    checkOutput("t5_buf_hold", 32'(buf_count),      32'd2);
    checkOutput("t5_metaA",    32'(pkt_meta_valid), 32'd1);
    checkOutput("t5_cmdA",     32'(pkt_cmd),        32'h31);
    checkOutput("t5_lenA",     32'(pkt_length),     32'd1);
    pkt_meta_ready = 1'b1;
    stepCycle();
    pkt_meta_ready = 1'b0;
    checkOutput("t5_pdA", 32'(pkt_payload_data), 32'h7E);
    checkOutput("t5_plA", 32'(pkt_payload_last), 32'd1);
    pkt_payload_ready = 1'b1;
    stepCycle();
    pkt_payload_ready = 1'b0;
    checkOutput("t5_metaB", 32'(pkt_meta_valid), 32'd1);
    checkOutput("t5_cmdB",  32'(pkt_cmd),        32'h32);
    checkOutput("t5_lenB",  32'(pkt_length),     32'd2);
    checkOutput("t5_bufB",  32'(buf_count),      32'd1);
    pkt_meta_ready = 1'b1;
    stepCycle();
    pkt_meta_ready = 1'b0;
    checkOutput("t5_pdB0", 32'(pkt_payload_data), 32'h11);
    checkOutput("t5_plB0", 32'(pkt_payload_last), 32'd0);
    pkt_payload_ready = 1'b1;
    stepCycle();
    checkOutput("t5_pdB1", 32'(pkt_payload_data), 32'h22);
    checkOutput("t5_plB1", 32'(pkt_payload_last), 32'd1);
    stepCycle();
    pkt_payload_ready = 1'b0;
    checkOutput("t5_buf_end",  32'(buf_count),      32'd0);
    checkOutput("t5_meta_end", 32'(pkt_meta_valid), 32'd0);

    // 6. Timeout 50 cycles after CMD, then a full frame is accepted
    $display("[TB] timeout");
    applyStimulus(8'hAA); applyStimulus(8'h55); applyStimulus(8'h10);
    repeat (49) stepCycle();
    checkOutput("t6_errv_49", 32'(err_valid), 32'd0);
    stepCycle();
    checkOutput("t6_errv_50", 32'(err_valid), 32'd1);
    checkOutput("t6_errc",    32'(err_code),  32'd3);
    applyStimulus(8'hAA); applyStimulus(8'h55); applyStimulus(8'h40);
    applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'hBF);
    checkOutput("t6_meta", 32'(pkt_meta_valid), 32'd1);
    checkOutput("t6_cmd",  32'(pkt_cmd),        32'h40);
    checkOutput("t6_len",  32'(pkt_length),     32'd0);
    pkt_meta_ready = 1'b1;
    stepCycle();
    pkt_meta_ready = 1'b0;
    checkOutput("t6_buf_end", 32'(buf_count), 32'd0);

    // Statistics: 5 commits, 4 error pulses when the counters are built
    checkOutput("stat_good", 32'(stat_good), 32'(5 * STATS_ON));
    checkOutput("stat_bad",  32'(stat_bad),  32'(4 * STATS_ON));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/uart_packet_rx_mb.md
Name: uart_packet_rx_mb

Overview:
Multi-buffered UART frame depacketizer, successor to the single-buffer packet handler. It parses frames from the uart_rx byte stream and validates checksum and length. Good frames are committed into NUM_BUFS payload slots, so reception continues while earlier frames drain through a meta + payload stream to the command decoder. Adds an inter-byte timeout, explicit error reporting and buffer-overrun detection.

Parameters:
MAX_PAYLOAD_BYTES, 512, payload capacity per slot; lengths above this are rejected.
NUM_BUFS, 2, number of frame slots (>=1, any integer; indices wrap explicitly).
TIMEOUT_CYCLES, 100000, clk cycles of mid-frame silence before abort; 0 disables the timeout.
HDR0, 8'hAA, first header byte.
HDR1, 8'h55, second header byte.
STAT_WIDTH, 16, width of the optional statistics counters.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_byte  in  8  received byte
rx_byte_valid  in  1  one-cycle strobe per byte
rx_byte_ready  out  1  constant 1 (the UART cannot stall); frames are dropped, never back-pressured
pkt_meta_valid  out  1  committed frame metadata available
pkt_meta_ready  in  1  consumer accepts metadata
pkt_cmd  out  8  command byte of the head slot
pkt_length  out  16  payload length of the head slot
pkt_payload_data  out  8  payload byte
pkt_payload_valid  out  1  payload byte valid
pkt_payload_last  out  1  final payload byte
pkt_payload_ready  in  1  consumer accepts payload byte
err_valid  out  1  one-cycle error pulse
err_code  out  3  1 len overflow, 2 checksum, 3 timeout, 4 no free slot
buf_count  out  $clog2(NUM_BUFS+1)  committed, undrained slots
stat_good  out  STAT_WIDTH  good-frame counter (optional feature)
stat_bad  out  STAT_WIDTH  error counter (optional feature)

Behaviour:
- Frame format: HDR0 HDR1 CMD LEN_L LEN_H PAYLOAD[LEN] CHK. CHK = ~(CMD+LEN_L+LEN_H+sum payload), mod 256.
- Reset values: all outputs 0 except rx_byte_ready=1. Slots, pointers and counters are cleared; frames buffered at reset are lost.
- Write FSM states: HUNT, HDR1, CMD, LEN_L, LEN_H, PAYLOAD, CHECK.
- HUNT: on HDR0 go to HDR1.
- HDR1: on HDR1 byte -> CMD if buf_count<NUM_BUFS; otherwise err 4 and return to HUNT. A repeated HDR0 stays in HDR1. Any other byte returns to HUNT.
- LEN_H: len>MAX_PAYLOAD_BYTES -> err 1 and HUNT; the payload bytes are then hunted through. len==0 -> CHECK; else -> PAYLOAD.
- PAYLOAD: write to slot[wr_slot][offset]; after len bytes go to CHECK.
- CHECK: match -> commit (wr_slot advances, wrapping NUM_BUFS-1 -> 0) and return to HUNT. Mismatch -> err 2; the slot is not advanced and its contents are overwritten later.
- Timeout: in any state other than HUNT, an idle counter increments each cycle without rx_byte_valid. At TIMEOUT_CYCLES it raises err 3 and returns to HUNT. Any valid byte clears the counter.
- err_valid and err_code are registered, asserted the cycle after the triggering byte or timeout; err_code holds its value between pulses.
- Read side states: R_META, R_PAYLOAD.
- pkt_meta_valid = buf_count>0 in R_META, registered; it first rises the cycle after the CHK byte. The cmd/length outputs show the head slot and are stable while valid.
- Meta handshake: len==0 frees the slot immediately. Otherwise go to R_PAYLOAD and stream offsets 0..len-1 with combinational slot read; pkt_payload_last marks offset len-1. The handshake on last frees the slot and returns to R_META.
- Commit and free in the same cycle: buf_count unchanged.
- A valid signal never drops without its handshake.

Optional Feature:
UART_PKT_STATS_EN: when defined, stat_good increments on every commit and stat_bad on every err_valid. Both counters saturate at all-ones and are cleared by reset. When undefined, both ports are driven constant 0 and no counter logic is built.

Decomposition:
- uart_pkt_pkg holds: the error enum (ERR_NONE, ERR_LEN, ERR_CHK, ERR_TIMEOUT, ERR_NOBUF), the write and read state enums, and the default header localparams.
- Sub-module uart_pkt_slot_ram: NUM_BUFS*MAX_PAYLOAD_BYTES bytes, one write port, one asynchronous read port, addressed as {slot, offset}.

Test Plan:
1. Good frame: AA 55 10 03 00 01 02 03 E6 -> meta cmd 0x10, len 3; payload 01,02,03 with last on 03; no err; stat_good=1.
2. Bad checksum: same frame with CHK 0x00 -> err_code 2 pulse; no meta; buf_count stays 0.
3. Length overflow: AA 55 10 01 02 -> err_code 1 after LEN_H; the next AA 55 20 00 00 DF is accepted as a zero-length frame.
4. Zero-length: AA 55 20 00 00 DF -> meta cmd 0x20, len 0; no payload valid; slot freed on meta handshake.
5. Overrun (NUM_BUFS=2, pkt_meta_ready=0): three good frames -> buf_count=2; third gives err 4. Then draining yields frames 1 and 2 in order.
6. Timeout (TIMEOUT_CYCLES=50): AA 55 10, then silence -> err_code 3 exactly 50 cycles after CMD; a new full frame is then accepted.
